avst_pkt_fifo: RTL and testbench

AVST_PKT_FIFO -- requirements
Module: avst_pkt_fifo

---
 rtl/avst_pkt_fifo_if.sv | 31 +++
 rtl/avst_pkt_fifo.sv | 123 ++++++++++++
 tb/tb_avst_pkt_fifo.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/avst_pkt_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : avst_pkt_fifo_if
// Description : Avalon-ST beat bundle (handshake plus payload fields).
//               The master modport drives the beat and the slave returns ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface avst_pkt_fifo_if #(
    parameter int DATA_W    = 128,
    parameter int EMPTY_W   = 4,
    parameter int CHANNEL_W = 128
) ();
    logic                 valid;
    logic                 ready;
    logic [DATA_W-1:0]    data;
    logic [CHANNEL_W-1:0] channel;
    logic [EMPTY_W-1:0]   empty;
    logic                 sop;
    logic                 eop;

    modport master (
        output valid, data, channel, empty, sop, eop,
        input  ready
    );

    modport slave (
        input  valid, data, channel, empty, sop, eop,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/avst_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : avst_pkt_fifo
// Description : Avalon-ST packet FIFO with one-cycle first-word latency.
//               Define AVST_PKT_FIFO_SAF_EN for store-and-forward release.
// Revision    : 1.0 - initial release
// ============================================================================
module avst_pkt_fifo #(
    parameter int DEPTH     = 16,
    parameter int DATA_W    = 128,
    parameter int EMPTY_W   = 4,
    parameter int CHANNEL_W = 128
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    avst_pkt_fifo_if.slave              avst_in,
    avst_pkt_fifo_if.master             avst_out,
    output logic [$clog2(DEPTH):0]      level
);
    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = AW + 1;
    localparam int ENTRY_W = DATA_W + CHANNEL_W + EMPTY_W + 2;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_head;

    assign w_push     = avst_in.valid && in_ready_q;
    assign w_pop      = out_valid_q && avst_out.ready;
    assign w_wr_entry = {avst_in.sop, avst_in.eop, avst_in.empty,
                         avst_in.channel, avst_in.data};
    assign w_head     = mem[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = w_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = w_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        level_d  = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase
        in_ready_d = (level_d != LEVEL_FULL);
    end

`ifdef AVST_PKT_FIFO_SAF_EN
    logic [LW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          w_push_eop;
    logic          w_pop_eop;

    assign w_push_eop = w_push && avst_in.eop;
    assign w_pop_eop  = w_pop && w_head[ENTRY_W-2];

    // A full FIFO releases even without a stored eop so oversized packets cannot deadlock.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (w_push_eop && !w_pop_eop) begin
            pkt_cnt_d = pkt_cnt_q + LEVEL_ONE;
        end else if (w_pop_eop && !w_push_eop) begin
            pkt_cnt_d = pkt_cnt_q - LEVEL_ONE;
        end
        out_valid_d = (level_d != '0) &&
                      ((pkt_cnt_d != '0) || (level_d == LEVEL_FULL));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
`else
    always_comb begin
        out_valid_d = (level_d != '0);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem[wr_ptr_q] <= w_wr_entry;
        end
    end

    assign avst_in.ready = in_ready_q;
    assign avst_out.valid = out_valid_q;
    assign {avst_out.sop, avst_out.eop, avst_out.empty,
            avst_out.channel, avst_out.data} = w_head;
    assign level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_avst_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_avst_pkt_fifo
// Description : Directed self-checking bench for avst_pkt_fifo (DEPTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avst_pkt_fifo;
    localparam int DEPTH     = 16;
    localparam int DATA_W    = 128;
    localparam int EMPTY_W   = 4;
    localparam int CHANNEL_W = 128;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] level;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    avst_pkt_fifo_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CHANNEL_W(CHANNEL_W)) in_if ();
    avst_pkt_fifo_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CHANNEL_W(CHANNEL_W)) out_if ();

    avst_pkt_fifo #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CHANNEL_W(CHANNEL_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .avst_in  (in_if),
        .avst_out (out_if),
        .level    (level)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic s,
                         input logic e, input logic [3:0] emp, input logic [31:0] ch);
        in_if.valid   = v;
        in_if.data    = DATA_W'(d);
        in_if.sop     = s;
        in_if.eop     = e;
        in_if.empty   = emp;
        in_if.channel = CHANNEL_W'(ch);
    endtask

    task automatic idle;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        out_if.ready = 1'b0;
        idle();
        tick();
        tick();
        checks++;
        if (level !== 5'd0) begin
            failures++; $display("FAIL reset_level actual=%0d required=0", level);
        end
        checks++;
        if (out_if.valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid actual=%b required=0", out_if.valid);
        end
        checks++;
        if (in_if.ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready actual=%b required=0", in_if.ready);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (in_if.ready !== 1'b1) begin
            failures++; $display("FAIL post_reset_in_ready actual=%b required=1", in_if.ready);
        end
    endtask

    task automatic test_single_beat;
        out_if.ready = 1'b1;
        drive(1'b1, 32'h1, 1'b1, 1'b1, 4'd4, 32'd7);
        tick();
        idle();
        checks++;
        if (out_if.valid !== 1'b1 || out_if.data !== DATA_W'(1) || out_if.sop !== 1'b1 ||
            out_if.eop !== 1'b1 || out_if.empty !== 4'd4 || out_if.channel !== CHANNEL_W'(7)) begin
            failures++;
            $display("FAIL single_fields actual v=%b d=%0h s=%b e=%b emp=%0d ch=%0d required v=1 d=1 s=1 e=1 emp=4 ch=7",
                     out_if.valid, out_if.data, out_if.sop, out_if.eop, out_if.empty, out_if.channel);
        end
        tick();
        checks++;
        if (level !== 5'd0 || out_if.valid !== 1'b0) begin
            failures++; $display("FAIL single_drain actual level=%0d v=%b required level=0 v=0", level, out_if.valid);
        end
    endtask

    task automatic test_fill;
        out_if.ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'(i), i == 0, i == DEPTH - 1, 4'h0, 32'h0);
            tick();
        end
        checks++;
        if (in_if.ready !== 1'b0 || level !== 5'd16) begin
            failures++; $display("FAIL fill_full actual ready=%b level=%0d required ready=0 level=16", in_if.ready, level);
        end
        drive(1'b1, 32'h99, 1'b0, 1'b0, 4'h0, 32'h0);
        tick();
        idle();
        checks++;
        if (level !== 5'd16) begin
            failures++; $display("FAIL fill_overflow_rejected actual level=%0d required=16", level);
        end
        out_if.ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (out_if.valid !== 1'b1 || out_if.data !== DATA_W'(i)) begin
                failures++; $display("FAIL fill_order idx=%0d actual v=%b d=%0h required v=1 d=%0h", i, out_if.valid, out_if.data, i);
            end
            tick();
        end
        checks++;
        if (level !== 5'd0) begin
            failures++; $display("FAIL fill_empty_after actual level=%0d required=0", level);
        end
    endtask

    task automatic test_back_to_back;
        out_if.ready = 1'b1;
        for (int c = 0; c <= 1000; c++) begin
            if (c < 1000) drive(1'b1, 32'(c), 1'b1, 1'b1, 4'h0, 32'h0);
            else idle();
            if (c > 0) begin
                checks++;
                if (out_if.valid !== 1'b1 || out_if.data !== DATA_W'(c - 1) || level !== 5'd1 || in_if.ready !== 1'b1) begin
                    failures++;
                    $display("FAIL stream cyc=%0d actual v=%b d=%0h level=%0d rdy=%b required v=1 d=%0h level=1 rdy=1",
                             c, out_if.valid, out_if.data, level, in_if.ready, c - 1);
                end
            end
            tick();
        end
        checks++;
        if (level !== 5'd0) begin
            failures++; $display("FAIL stream_drain actual level=%0d required=0", level);
        end
    endtask

    task automatic test_gapped_packet;
        out_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40 + 32'(i), i == 0, i == 3, 4'h0, 32'h0);
            tick();
            idle();
`ifdef AVST_PKT_FIFO_SAF_EN
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    checks++;
                    if (out_if.valid !== 1'b0) begin
                        failures++; $display("FAIL saf_hold beat=%0d actual v=%b required v=0", i, out_if.valid);
                    end
                    if (g < 2) tick();
                end
            end
`else
            checks++;
            if (out_if.valid !== 1'b1 || out_if.data !== DATA_W'(32'h40 + 32'(i))) begin
                failures++; $display("FAIL cut_through beat=%0d actual v=%b d=%0h required v=1 d=%0h", i, out_if.valid, out_if.data, 32'h40 + i);
            end
            tick();
            checks++;
            if (out_if.valid !== 1'b0) begin
                failures++; $display("FAIL cut_through_gap beat=%0d actual v=%b required v=0", i, out_if.valid);
            end
            tick();
`endif
        end
`ifdef AVST_PKT_FIFO_SAF_EN
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_if.valid !== 1'b1 || out_if.data !== DATA_W'(32'h40 + 32'(j))) begin
                failures++; $display("FAIL saf_burst beat=%0d actual v=%b d=%0h required v=1 d=%0h", j, out_if.valid, out_if.data, 32'h40 + j);
            end
            tick();
        end
`endif
        checks++;
        if (level !== 5'd0) begin
            failures++; $display("FAIL gapped_drain actual level=%0d required=0", level);
        end
    endtask

    // Streams n beats of one packet with out_ready=1, checking order as they pop.
    task automatic send_recv(input int n, input logic [31:0] base, input logic chk_full);
        int  sent = 0;
        int  rcvd = 0;
        bit  in_fire;
        bit  out_fire;
        out_if.ready = 1'b1;
        for (int cyc = 0; cyc < 400 && rcvd < n; cyc++) begin
            if (sent < n) drive(1'b1, base + 32'(sent), sent == 0, sent == n - 1, 4'h0, 32'h0);
            else idle();
            in_fire  = in_if.valid && in_if.ready;
            out_fire = out_if.valid && out_if.ready;
            if (out_fire) begin
                if (chk_full && rcvd == 0) begin
                    checks++;
                    if (level !== 5'd16) begin
                        failures++; $display("FAIL saf_release_level actual=%0d required=16", level);
                    end
                end
                checks++;
                if (out_if.data !== DATA_W'(base + 32'(rcvd)) || out_if.sop !== (rcvd == 0) || out_if.eop !== (rcvd == n - 1)) begin
                    failures++;
                    $display("FAIL pkt_order idx=%0d actual d=%0h s=%b e=%b required d=%0h s=%b e=%b",
                             rcvd, out_if.data, out_if.sop, out_if.eop, base + rcvd, rcvd == 0, rcvd == n - 1);
                end
            end
            tick();
            if (in_fire) sent++;
            if (out_fire) rcvd++;
        end
        idle();
        checks++;
        if (rcvd != n || level !== 5'd0) begin
            failures++; $display("FAIL pkt_complete actual beats=%0d level=%0d required beats=%0d level=0", rcvd, level, n);
        end
    endtask

    task automatic test_long_packet;
`ifdef AVST_PKT_FIFO_SAF_EN
        send_recv(20, 32'h100, 1'b1);
`else
        send_recv(20, 32'h100, 1'b0);
`endif
    endtask

    task automatic test_reset_mid_packet;
        out_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(i), i == 0, 1'b0, 4'h0, 32'h0);
            tick();
        end
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (level !== 5'd0 || out_if.valid !== 1'b0 || in_if.ready !== 1'b1) begin
            failures++; $display("FAIL midreset_state actual level=%0d v=%b rdy=%b required level=0 v=0 rdy=1", level, out_if.valid, in_if.ready);
        end
        send_recv(6, 32'h300, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_fill();
        test_back_to_back();
        test_gapped_packet();
        test_long_packet();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
